// File: rtl/note_draw_sequencer.sv
// note_draw_sequencer: owns the 15 note slots, moves them once per frame and
// sequences the drawer (clear, then 15 x 16-cycle slot draws) with a plot
// strobe delayed one cycle to line up with the drawer's registered output.

// One note slot: position/colour/active state, changed only on the update cycle.
module note_slot #(
  parameter logic [7:0] SPAWN_X  = 8'd160,
  parameter logic [7:0] RETIRE_X = 8'd22,
  parameter logic [7:0] STEP     = 8'd2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       upd,
  input  logic       load,
  input  logic [2:0] load_colour,
  output logic       active,
  output logic [7:0] x,
  output logic [2:0] colour
);
  // load is only raised for a slot that was inactive, so it never races a move
  always_ff @(posedge CLK) begin
    if (reset) begin
      active <= 1'b0;
      x      <= '0;
      colour <= '0;
    end else if (upd) begin
      if (load) begin
        active <= 1'b1;
        x      <= SPAWN_X;
        colour <= load_colour;
      end else if (active) begin
        if (x < RETIRE_X) begin
          active <= 1'b0;
          x      <= '0;
          colour <= '0;
        end else begin
          x <= x - STEP;
        end
      end
    end
  end
endmodule

module note_draw_sequencer #(
  parameter int FRAME_DIV    = 833333,
  parameter int CLEAR_CYCLES = 19764,
  parameter int SPAWN_X      = 160,
  parameter int END_X        = 20,
  parameter int STEP         = 2
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         enable,
  input  logic         spawn_req,
  input  logic [2:0]   spawn_colour,
  output logic [4:0]   command,
  output logic         plot,
  output logic [119:0] note_x,
  output logic [44:0]  note_colour,
  output logic [14:0]  note_active,
  output logic         busy,
  output logic         spawn_drop,
  output logic         frame_overrun
);
  localparam int NUM_SLOTS = 15;
  localparam int DIV_W     = $clog2(FRAME_DIV + 1);
  localparam int CLR_W     = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, UPDATE} state_t;

  state_t                          state, state_nx;
  logic [DIV_W-1:0]                div_cnt;
  logic [CLR_W-1:0]                clr_cnt;
  logic [3:0]                      slot, sub;
  logic                            tick, upd, any_free, found;
  logic                            pend_vld;
  logic [2:0]                      pend_col;
  logic [NUM_SLOTS-1:0]            load;
  logic [NUM_SLOTS-1:0][7:0]       x_arr;
  logic [NUM_SLOTS-1:0][2:0]       col_arr;

  assign tick     = (div_cnt == DIV_W'(FRAME_DIV - 1));
  assign upd      = (state == UPDATE);
  assign busy     = (state != IDLE);
  assign any_free = ~&note_active;

  // Free-running frame divider, independent of enable and FSM state
  always_ff @(posedge CLK) begin
    if (reset || tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + 1'b1;
  end

  // State register plus clear/draw counters, which idle at zero outside their state
  always_ff @(posedge CLK) begin
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
      slot    <= '0;
      sub     <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                clr_cnt <= '0;
      if (state == DRAW) begin
        sub <= sub + 1'b1;
        if (sub == 4'hF) slot <= slot + 1'b1;
      end else begin
        sub  <= '0;
        slot <= '0;
      end
    end
  end

  // Next state and drawer command; anything but a slot draw shows 15
  always_comb begin
    state_nx = state;
    command  = 5'd15;
    case (state)
      IDLE:   if (tick && enable) state_nx = CLEAR;
      CLEAR:  if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) state_nx = DRAW;
      DRAW: begin
        command = {1'b0, slot};
        if (slot == 4'd14 && sub == 4'hF) state_nx = UPDATE;
      end
      UPDATE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Plot strobe trails the pixel-producing states by the drawer's one register
  always_ff @(posedge CLK) begin
    if (reset) plot <= 1'b0;
    else       plot <= (state == CLEAR) || (state == DRAW);
  end

  // Pending spawn holder and the drop/overrun pulses
  always_ff @(posedge CLK) begin
    if (reset) begin
      pend_vld      <= 1'b0;
      pend_col      <= '0;
      spawn_drop    <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      // a request colliding with the consuming update is accepted, not dropped
      spawn_drop    <= (spawn_req && pend_vld && !upd) || (upd && pend_vld && !any_free);
      frame_overrun <= tick && (state != IDLE);
      if (spawn_req && (!pend_vld || upd)) begin
        pend_vld <= 1'b1;
        pend_col <= spawn_colour;
      end else if (upd) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Lowest-index slot that was free before this update takes the pending note
  always_comb begin
    load  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!note_active[i] && !found) begin
        load[i] = upd && pend_vld;
        found   = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    note_slot #(
      .SPAWN_X  (8'(SPAWN_X)),
      .RETIRE_X (8'(END_X + STEP)),
      .STEP     (8'(STEP))
    ) u_slot (
      .CLK         (CLK),
      .reset       (reset),
      .upd         (upd),
      .load        (load[g]),
      .load_colour (pend_col),
      .active      (note_active[g]),
      .x           (x_arr[g]),
      .colour      (col_arr[g])
    );
  end

  assign note_x      = x_arr;
  assign note_colour = col_arr;
endmodule

// File: tb/tb_note_draw_sequencer.sv
// Directed bench for note_draw_sequencer with a short frame (200) and clear (20).
// Frame timeline after reset release (edge k = k-th edge): tick seen at E200,
// CLEAR E200..E219, DRAW E220..E459, UPDATE E460, IDLE + new slots after E461.
// A second tick lands at E400 (mid-DRAW) every frame, so frames repeat every 400.
module tb_note_draw_sequencer;
  logic         CLK = 1'b0;
  logic         reset, enable, spawn_req;
  logic [2:0]   spawn_colour;
  logic [4:0]   command;
  logic         plot, busy, spawn_drop, frame_overrun;
  logic [119:0] note_x;
  logic [44:0]  note_colour;
  logic [14:0]  note_active;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  note_draw_sequencer #(.FRAME_DIV(200), .CLEAR_CYCLES(20)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .enable        (enable),
    .spawn_req     (spawn_req),
    .spawn_colour  (spawn_colour),
    .command       (command),
    .plot          (plot),
    .note_x        (note_x),
    .note_colour   (note_colour),
    .note_active   (note_active),
    .busy          (busy),
    .spawn_drop    (spawn_drop),
    .frame_overrun (frame_overrun)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n edges, then sample 1 time unit later
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    cyc += n;
    #1;
  endtask

  task automatic go(input int e);
    step(e - cyc);
  endtask

  // request is sampled on the next edge
  task automatic pulse_spawn(input logic [2:0] c);
    spawn_req    = 1'b1;
    spawn_colour = c;
    step(1);
    spawn_req    = 1'b0;
  endtask

  // run until a frame has started and finished (slots updated, back in IDLE)
  task automatic wait_update();
    int n = 0;
    while (busy !== 1'b1 && n < 1000) begin step(1); n++; end
    while (busy !== 1'b0 && n < 2000) begin step(1); n++; end
    chk("frame_timeout", {127'b0, n < 2000}, 128'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; spawn_req = 1'b0; spawn_colour = '0;
    step(3);
    chk("rst_command", command, 5'd15);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", spawn_drop, 0);
    chk("rst_overrun", frame_overrun, 0);
    chk("rst_active", note_active, 0);
    chk("rst_x", note_x, 0);
    chk("rst_colour", note_colour, 0);
    reset = 1'b0; cyc = 0;

    // frame 1: spawn colour 100 while idle
    go(4); pulse_spawn(3'b100);
    go(199); chk("pre_tick_busy", busy, 0);
    chk("pre_tick_cmd", command, 15);
    go(200); chk("clear_busy", busy, 1);
    chk("clear_cmd", command, 15);
    chk("clear_plot0", plot, 0);
    go(201); chk("clear_plot1", plot, 1);
    go(219); chk("clear_last_cmd", command, 15);
    go(220); chk("draw_s0_first", command, 0);
    go(235); chk("draw_s0_last", command, 0);
    go(236); chk("draw_s1_first", command, 1);
    go(300); chk("draw_s5", command, 5);
    chk("draw_slots_stable", note_active, 0);
    go(400); chk("overrun_pulse", frame_overrun, 1);
    chk("overrun_draw_s11", command, 11);
    go(401); chk("overrun_clear", frame_overrun, 0);
    chk("overrun_draw_keep", command, 11);
    go(459); chk("draw_s14_last", command, 14);
    chk("draw_plot", plot, 1);
    go(460); chk("update_cmd", command, 15);
    chk("update_busy", busy, 1);
    chk("update_plot", plot, 1);
    chk("update_slots_old", note_active, 0);
    go(461); chk("idle_busy", busy, 0);
    chk("idle_plot", plot, 0);
    chk("idle_cmd", command, 15);
    chk("spawn_active", note_active, 15'h0001);
    chk("spawn_x", note_x[7:0], 160);
    chk("spawn_colour", note_colour[2:0], 3'b100);

    // frame 2: two requests, the second is dropped
    go(469); pulse_spawn(3'b010);
    chk("first_req_nodrop", spawn_drop, 0);
    go(474); pulse_spawn(3'b111);
    chk("second_req_drop", spawn_drop, 1);
    go(476); chk("drop_one_cycle", spawn_drop, 0);
    go(861); chk("f2_active", note_active, 15'h0003);
    chk("f2_x", note_x[15:0], {8'd160, 8'd158});
    chk("f2_colour", note_colour[5:0], {3'b010, 3'b100});

    // frame 3: pending 011, a new request lands on the consuming UPDATE cycle
    go(1099); pulse_spawn(3'b011);
    go(1260); chk("f3_in_update", command, 15);
    chk("f3_busy", busy, 1);
    pulse_spawn(3'b101);
    chk("f3_nodrop", spawn_drop, 0);
    chk("f3_active", note_active, 15'h0007);
    chk("f3_x2", note_x[23:16], 160);
    chk("f3_col2", note_colour[8:6], 3'b011);
    chk("f3_x0", note_x[7:0], 156);

    // frame 4: the request that arrived during UPDATE is placed now
    wait_update();
    chk("f4_cycle", cyc, 1661);
    chk("f4_active", note_active, 15'h000F);
    chk("f4_col3", note_colour[11:9], 3'b101);
    chk("f4_x3", note_x[31:24], 160);

    // frames 5..15 fill the remaining slots
    for (int f = 5; f <= 15; f++) begin
      pulse_spawn(3'(f));
      wait_update();
    end
    chk("full_active", note_active, 15'h7FFF);
    chk("full_col14", note_colour[44:42], 3'b111);
    chk("full_col4", note_colour[14:12], 3'b101);
    chk("full_x14", note_x[119:112], 160);
    chk("full_x0", note_x[7:0], 132);

    // frame 16: no free slot, pending is discarded
    pulse_spawn(3'b001);
    wait_update();
    chk("f16_cycle", cyc, 6461);
    chk("full_drop", spawn_drop, 1);
    chk("full_active_kept", note_active, 15'h7FFF);
    chk("full_x0_moved", note_x[7:0], 130);
    chk("full_x14_moved", note_x[119:112], 158);
    step(1); chk("full_drop_clear", spawn_drop, 0);

    // enable low: tick at E6600 is ignored without overrun
    enable = 1'b0;
    go(6600); chk("disabled_idle", busy, 0);
    go(6601); chk("disabled_no_overrun", frame_overrun, 0);
    chk("disabled_still_idle", busy, 0);
    enable = 1'b1;
    wait_update();
    chk("reenable_cycle", cyc, 7061);
    chk("reenable_x0", note_x[7:0], 128);

    // march slot 0 down to the retire boundary
    for (int k = 0; k < 80 && note_x[7:0] != 8'd22; k++) wait_update();
    chk("edge_x0", note_x[7:0], 22);
    chk("edge_x1", note_x[15:8], 24);
    wait_update();
    chk("edge22_moves", note_x[7:0], 20);
    chk("edge22_active", note_active[0], 1);
    chk("edge24_moves", note_x[15:8], 22);
    wait_update();
    chk("retire_active", note_active[1:0], 2'b10);
    chk("retire_x", note_x[7:0], 0);
    chk("retire_colour", note_colour[2:0], 0);
    chk("edge22_not_retired", note_x[15:8], 20);

    // reset in the middle of DRAW, with a spawn pending
    pulse_spawn(3'b110);
    begin
      int n = 0;
      while (command == 5'd15 && n < 1000) begin step(1); n++; end
      chk("reach_draw", {127'b0, n < 1000}, 128'd1);
    end
    step(5);
    reset = 1'b1;
    step(1);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd", command, 15);
    chk("midrst_plot", plot, 0);
    chk("midrst_active", note_active, 0);
    chk("midrst_x", note_x, 0);
    chk("midrst_colour", note_colour, 0);
    reset = 1'b0; cyc = 0;
    wait_update();
    chk("postrst_cycle", cyc, 461);
    chk("postrst_pending_lost", note_active, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/note_draw_sequencer.md
Name: note_draw_sequencer

Overview:
- Upstream stage of the note-lane drawer.
- Owns the 15 note slots (X position, colour, active flag) and advances them left once per frame.
- Each frame, sequences the drawer's command input: one full-screen clear, then 15 slot draws of 16 cycles each.
- Generates the VGA plot strobe, aligned to the drawer's one-cycle registered output.

Parameters:
FRAME_DIV, 833333, CLK cycles per frame tick (60 Hz at 50 MHz)
CLEAR_CYCLES, 19764, cycles spent in clear command (162 x 122 pixels)
SPAWN_X, 160, X given to a newly spawned note
END_X, 20, a note whose X falls below END_X+STEP is retired
STEP, 2, pixels moved left per frame

Ports:
CLK  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
enable  in  1  when low, no new frame starts; the current frame completes
spawn_req  in  1  one-cycle pulse: request a new note
spawn_colour  in  3  colour for requested note
command  out  5  drawer command; bit 4 always 0; 0-14 = draw slot n, 15 = clear
plot  out  1  VGA write strobe, aligned with drawer OutX/OutY/colour
note_x  out  120  slot n X at [8n+7:8n]
note_colour  out  45  slot n colour at [3n+2:3n]; 000 when slot inactive
note_active  out  15  per-slot active flag
busy  out  1  high outside IDLE
spawn_drop  out  1  one-cycle pulse: spawn request discarded
frame_overrun  out  1  one-cycle pulse: frame tick arrived while busy

Behaviour:
- Reset values:
  - FSM = IDLE; command = 5'b01111.
  - plot, busy, spawn_drop, frame_overrun = 0.
  - All note_x, note_colour, note_active = 0.
  - Frame divider = 0; pending-spawn register empty.
- Frame divider counts 0..FRAME_DIV-1 and pulses tick on wrap. It free-runs regardless of enable.
- FSM states: IDLE -> CLEAR -> DRAW -> UPDATE -> IDLE.
- IDLE:
  - command = 15; plot = 0.
  - On tick with enable = 1, go to CLEAR.
  - On tick with enable = 0, stay in IDLE; no overrun.
- CLEAR:
  - command = 15 for exactly CLEAR_CYCLES cycles, then go to DRAW with slot = 0, sub-counter = 0.
- DRAW:
  - command = slot for 16 cycles; sub-counter runs 0..15.
  - On sub-counter = 15, slot increments.
  - After slot 14, sub-counter 15: go to UPDATE.
  - Total DRAW time: 240 cycles.
  - Inactive slots are still drawn for their 16 cycles with colour 000, which erases them.
- plot = 1 one cycle after each CLEAR or DRAW cycle, i.e. plot(t) = (state(t-1) in {CLEAR, DRAW}). This matches the drawer's registered latency.
- UPDATE (single cycle), using the pre-update active vector:
  - Each active slot with X < END_X+STEP is retired: active = 0, X = 0, colour = 0.
  - Every other active slot: X = X - STEP (8-bit, no wrap possible).
  - If a spawn is pending, the lowest-index slot inactive before this update gets active = 1, X = SPAWN_X, colour = pending colour, and pending is cleared.
  - If no slot was free, the spawn is discarded, spawn_drop pulses, and pending is cleared.
  - Next state: IDLE.
- Spawn capture (any state): spawn_req sets pending with spawn_colour.
  - If pending is already set, the new request is dropped and spawn_drop pulses.
  - spawn_req in the same cycle UPDATE consumes pending: UPDATE uses the old pending, and the new request becomes pending.
- Tick while not in IDLE: ignored, frame_overrun pulses; the frame in progress is unaffected.
- note_x, note_colour and note_active change only in UPDATE (or reset). They are stable during CLEAR and DRAW.
- Frame length: CLEAR_CYCLES + 240 + 1 cycles, plus 1 cycle IDLE-to-CLEAR entry.
- Reset mid-frame: next cycle is IDLE with all reset values; any pending spawn is lost.

Test Plan:
- Reset, enable=1, FRAME_DIV=30000 -> first tick at cycle 29999; CLEAR holds command=15 for 19764 cycles; plot rises 1 cycle after CLEAR entry; busy=1.
- DRAW sequencing -> command steps 0,1,...,14, each held 16 cycles (240 total); then 1 UPDATE cycle; then IDLE with command=15 and plot=0 one cycle later.
- spawn_req with colour 3'b100 in IDLE -> after next UPDATE, slot 0 active, note_x[7:0]=160, note_colour[2:0]=100; subsequent frames give X=158, 156, ...
- Note at X=21 (END_X=20, STEP=2) -> retired at UPDATE: active=0, X=0, colour=000. Note at X=22 -> moves to X=20.
- Two spawn_req pulses in one frame -> the second raises spawn_drop. With all 15 slots active, a pending spawn raises spawn_drop at UPDATE and no slot changes.
- Tick injected during DRAW (short FRAME_DIV) -> frame_overrun pulses once and the DRAW sequence continues unchanged. Reset asserted mid-DRAW -> IDLE next cycle, all slots cleared.
